// File: rtl/nfc_seq_pkg.sv
// Shared types and constants for the NV-DDR data-output (read) burst sequencer.
package nfc_seq_pkg;

  localparam int PREAMBLE_CYCLES     = 2;
  localparam int POSTAMBLE_CYCLES    = 2;
  localparam int BUFFER_RESET_CYCLES = 4;
  localparam int DRAIN_TIMEOUT       = 256;
  localparam int MAX_WORDS           = 2048;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAITDLY,
    ST_BRST,
    ST_PRE,
    ST_TOGGLE,
    ST_POST,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } seq_state_e;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_LENGTH     = 2'b01;
  localparam logic [1:0] ERR_EARLY_LAST = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

  localparam logic [3:0] RE_IDLE   = 4'b1111;
  localparam logic [3:0] RE_LOW    = 4'b0000;
  localparam logic [3:0] RE_TOGGLE = 4'b0011;

  function automatic logic length_legal(input logic [11:0] len);
    return (len != 12'd0) && ({1'b0, len} <= 13'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/nfc_beat_counter.sv
// Counts capture-stream beats for one burst and flags early Last and drain timeout.
module nfc_beat_counter
  import nfc_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        count_en_i,
  input  logic        drain_i,
  input  logic        valid_i,
  input  logic        ready_i,
  input  logic        last_i,
  input  logic [11:0] length_i,
  output logic        count_hit_o,
  output logic        early_last_o,
  output logic        timeout_o
);

  logic [11:0] count_q, count_d;
  logic        early_q, early_d;
  logic [8:0]  idle_q, idle_d;
  logic        beat;
  logic        early_now;
  logic [12:0] count_inc;

  assign beat      = count_en_i & valid_i & ready_i;
  assign count_inc = {1'b0, count_q} + {12'd0, beat};
  // Hit also covers the case where all words arrived before DRAIN.
  assign count_hit_o  = count_inc >= {1'b0, length_i};
  assign early_now    = beat & last_i & (count_inc < {1'b0, length_i});
  assign early_last_o = early_q | early_now;
  assign timeout_o    = drain_i & ~beat & (idle_q == 9'(DRAIN_TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    early_d = early_q;
    idle_d  = idle_q;
    if (clear_i) begin
      count_d = 12'd0;
      early_d = 1'b0;
      idle_d  = 9'd0;
    end else begin
      if (beat) count_d = count_inc[11:0];
      if (early_now) early_d = 1'b1;
      if (!drain_i || beat) idle_d = 9'd0;
      else if (idle_q != 9'(DRAIN_TIMEOUT)) idle_d = idle_q + 9'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 12'd0;
      early_q <= 1'b0;
      idle_q  <= 9'd0;
    end else begin
      count_q <= count_d;
      early_q <= early_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: rtl/nfc_data_out_sequencer.sv
// Sequences one NV-DDR read burst: delay-ready wait, buffer reset, RE preamble/toggle/postamble, drain.
module nfc_data_out_sequencer
  import nfc_seq_pkg::*;
(
  input  logic        iSystemClock,
  input  logic        iModuleReset,
  input  logic        iCMDValid,
  output logic        oCMDReady,
  input  logic [11:0] iCMDLength,
  input  logic        iDelayReady,
  output logic        oPI_BuffReset,
  output logic        oPI_Buff_WE,
  output logic [3:0]  oAddressLatchEnable,
  output logic [3:0]  oPO_ReadEnable,
  input  logic        iStreamReady,
  output logic        oPI_Buff_Ready,
  input  logic        iPI_Buff_Valid,
  input  logic        iPI_Buff_Last,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError,
  output logic [1:0]  oErrorCode
);

  seq_state_e  state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] phase_q, phase_d;
  logic [1:0]  code_q, code_d;
  logic        ready_q, busy_q, done_q, err_q, brst_q, we_q;
  logic [3:0]  re_q, re_d;
  logic        clear;
  logic        count_hit, early_last, timeout;

  nfc_beat_counter u_beat_counter (
    .clk_i       (iSystemClock),
    .rst_i       (iModuleReset),
    .clear_i     (clear),
    .count_en_i  ((state_q == ST_TOGGLE) || (state_q == ST_POST) || (state_q == ST_DRAIN)),
    .drain_i     (state_q == ST_DRAIN),
    .valid_i     (iPI_Buff_Valid),
    .ready_i     (iStreamReady),
    .last_i      (iPI_Buff_Last),
    .length_i    (len_q),
    .count_hit_o (count_hit),
    .early_last_o(early_last),
    .timeout_o   (timeout)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    code_d  = code_q;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iCMDValid && ready_q) begin
          len_d = iCMDLength;
          clear = 1'b1;
          if (length_legal(iCMDLength)) begin
            code_d  = ERR_NONE;
            state_d = ST_WAITDLY;
          end else begin
            code_d  = ERR_LENGTH;
            state_d = ST_ERR;
          end
        end
      end
      ST_WAITDLY: if (iDelayReady) state_d = ST_BRST;
      ST_BRST:    if (phase_q == 12'(BUFFER_RESET_CYCLES - 1)) state_d = ST_PRE;
      ST_PRE:     if (phase_q == 12'(PREAMBLE_CYCLES - 1)) state_d = ST_TOGGLE;
      ST_TOGGLE:  if (phase_q == len_q - 12'd1) state_d = ST_POST;
      ST_POST:    if (phase_q == 12'(POSTAMBLE_CYCLES - 1)) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (count_hit) begin
          state_d = ST_DONE;
        end else if (early_last) begin
          code_d  = ERR_EARLY_LAST;
          state_d = ST_ERR;
        end else if (timeout) begin
          code_d  = ERR_TIMEOUT;
          state_d = ST_ERR;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
    phase_d = (state_d != state_q) ? 12'd0 : phase_q + 12'd1;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    re_d = RE_IDLE;
    if (state_d == ST_TOGGLE) re_d = RE_TOGGLE;
    else if ((state_d == ST_PRE) || (state_d == ST_POST)) re_d = RE_LOW;
  end

  always_ff @(posedge iSystemClock) begin
    if (iModuleReset) begin
      state_q <= ST_IDLE;
      len_q   <= 12'd0;
      phase_q <= 12'd0;
      code_q  <= ERR_NONE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      brst_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= RE_IDLE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      phase_q <= phase_d;
      code_q  <= code_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
      brst_q  <= (state_d == ST_BRST);
      we_q    <= (state_d == ST_TOGGLE);
      re_q    <= re_d;
    end
  end

  assign oCMDReady           = ready_q;
  assign oBusy               = busy_q;
  assign oDone               = done_q;
  assign oError              = err_q;
  assign oErrorCode          = code_q;
  assign oPI_BuffReset       = brst_q;
  assign oPI_Buff_WE         = we_q;
  assign oAddressLatchEnable = {3'b000, we_q};
  assign oPO_ReadEnable      = re_q;
  assign oPI_Buff_Ready      = iStreamReady;

endmodule

// File: tb/tb_nfc_data_out_sequencer.sv
// Directed bench for the read burst sequencer; cycle offsets are counted from the accept cycle.
module tb_nfc_data_out_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [11:0] cmd_len;
  logic        delay_ready, buff_reset, buff_we;
  logic [3:0]  ale, re;
  logic        stream_ready, buff_ready, buff_valid, buff_last;
  logic        busy, done, err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  int we_n, we_first, rst_n, rst_first, done_at, err_at, done_n, err_n, ale_bad;
  logic ready_after;
  logic [3:0] re_log [0:699];
  logic       busy_log [0:699];
  int pulses;

  nfc_data_out_sequencer dut (
    .iSystemClock       (clk),
    .iModuleReset       (rst),
    .iCMDValid          (cmd_valid),
    .oCMDReady          (cmd_ready),
    .iCMDLength         (cmd_len),
    .iDelayReady        (delay_ready),
    .oPI_BuffReset      (buff_reset),
    .oPI_Buff_WE        (buff_we),
    .oAddressLatchEnable(ale),
    .oPO_ReadEnable     (re),
    .iStreamReady       (stream_ready),
    .oPI_Buff_Ready     (buff_ready),
    .iPI_Buff_Valid     (buff_valid),
    .iPI_Buff_Last      (buff_last),
    .oBusy              (busy),
    .oDone              (done),
    .oError             (err),
    .oErrorCode         (err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command in the current cycle and records what the DUT does until one cycle after done/error.
  task automatic burst(input logic [11:0] len, input int beat_start, input int nbeats,
                       input int last_at, input int dly_low);
    int stop;
    we_n = 0; we_first = -1; rst_n = 0; rst_first = -1;
    done_at = -1; err_at = -1; done_n = 0; err_n = 0; ale_bad = 0;
    ready_after = 1'b0; stop = -1;
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_len     = len;
    delay_ready = (dly_low == 0);
    for (int k = 1; k < 700; k++) begin
      tick();
      cmd_valid = 1'b0;
      if (dly_low != 0 && k == dly_low + 1) delay_ready = 1'b1;
      buff_valid = (k >= beat_start) && (k < beat_start + nbeats);
      buff_last  = buff_valid && (k - beat_start + 1 == last_at);
      re_log[k]   = re;
      busy_log[k] = busy;
      if (buff_we) begin
        if (we_first < 0) we_first = k;
        we_n++;
      end
      if (buff_reset) begin
        if (rst_first < 0) rst_first = k;
        rst_n++;
      end
      if (ale !== {3'b000, buff_we}) ale_bad++;
      if (done) begin
        if (done_at < 0) done_at = k;
        done_n++;
      end
      if (err) begin
        if (err_at < 0) err_at = k;
        err_n++;
      end
      if (k == stop) begin
        ready_after = cmd_ready;
        break;
      end
      if (stop < 0 && (done || err)) stop = k + 1;
    end
    buff_valid  = 1'b0;
    buff_last   = 1'b0;
    delay_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = 12'd0; delay_ready = 1'b1;
    stream_ready = 1'b1; buff_valid = 1'b0; buff_last = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_buffreset", 32'(buff_reset), 32'd0);
    chk("rst_we", 32'(buff_we), 32'd0);
    chk("rst_ale", 32'(ale), 32'd0);
    chk("rst_re", 32'(re), 32'hF);
    rst = 1'b0;
    tick();
    stream_ready = 1'b0;
    #1;
    chk("stream_ready_low", 32'(buff_ready), 32'd0);
    stream_ready = 1'b1;
    #1;
    chk("stream_ready_high", 32'(buff_ready), 32'd1);
    tick();

    // Length 4, 4 beats at offsets 12..15 with Last on the 4th.
    burst(12'd4, 12, 4, 4, 0);
    chk("l4_busy_t1", 32'(busy_log[1]), 32'd1);
    chk("l4_rst_first", 32'(rst_first), 32'd2);
    chk("l4_rst_n", 32'(rst_n), 32'd4);
    chk("l4_we_first", 32'(we_first), 32'd8);
    chk("l4_we_n", 32'(we_n), 32'd4);
    chk("l4_ale_bad", 32'(ale_bad), 32'd0);
    chk("l4_re_waitdly", 32'(re_log[1]), 32'hF);
    chk("l4_re_brst", 32'(re_log[5]), 32'hF);
    chk("l4_re_pre0", 32'(re_log[6]), 32'h0);
    chk("l4_re_pre1", 32'(re_log[7]), 32'h0);
    chk("l4_re_tog0", 32'(re_log[8]), 32'h3);
    chk("l4_re_tog3", 32'(re_log[11]), 32'h3);
    chk("l4_re_post0", 32'(re_log[12]), 32'h0);
    chk("l4_re_post1", 32'(re_log[13]), 32'h0);
    chk("l4_re_drain", 32'(re_log[14]), 32'hF);
    chk("l4_done_at", 32'(done_at), 32'd16);
    chk("l4_done_n", 32'(done_n), 32'd1);
    chk("l4_err_n", 32'(err_n), 32'd0);
    chk("l4_code", 32'(err_code), 32'd0);
    chk("l4_ready_after", 32'(ready_after), 32'd1);

    // Illegal lengths.
    burst(12'd0, 1000, 0, 0, 0);
    chk("l0_err_at", 32'(err_at), 32'd1);
    chk("l0_err_n", 32'(err_n), 32'd1);
    chk("l0_code", 32'(err_code), 32'd1);
    chk("l0_rst_n", 32'(rst_n), 32'd0);
    chk("l0_ready_after", 32'(ready_after), 32'd1);
    burst(12'd2049, 1000, 0, 0, 0);
    chk("l2049_err_at", 32'(err_at), 32'd1);
    chk("l2049_code", 32'(err_code), 32'd1);
    chk("l2049_rst_n", 32'(rst_n), 32'd0);
    chk("l2049_we_n", 32'(we_n), 32'd0);

    // Length 8, Last on beat 5 (beats 16..20, DRAIN from 18).
    burst(12'd8, 16, 5, 5, 0);
    chk("l8_we_n", 32'(we_n), 32'd8);
    chk("l8_err_at", 32'(err_at), 32'd21);
    chk("l8_done_n", 32'(done_n), 32'd0);
    chk("l8_code", 32'(err_code), 32'd2);

    // Length 3, only 2 beats (13, 14); timeout after 256 idle cycles.
    burst(12'd3, 13, 2, 0, 0);
    chk("to_err_at", 32'(err_at), 32'd271);
    chk("to_err_n", 32'(err_n), 32'd1);
    chk("to_done_n", 32'(done_n), 32'd0);
    chk("to_code", 32'(err_code), 32'd3);

    // Delay line not ready for 100 cycles after accept.
    burst(12'd2, 112, 2, 2, 100);
    chk("dly_rst_first", 32'(rst_first), 32'd102);
    chk("dly_rst_n", 32'(rst_n), 32'd4);
    chk("dly_we_first", 32'(we_first), 32'd108);
    chk("dly_done_at", 32'(done_at), 32'd114);
    chk("dly_code", 32'(err_code), 32'd0);

    // Reset mid-TOGGLE on a length-16 burst.
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = 12'd16;
    tick();
    cmd_valid = 1'b0;
    repeat (9) tick();
    chk("mid_we_before", 32'(buff_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_we", 32'(buff_we), 32'd0);
    chk("mid_re", 32'(re), 32'hF);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || err || buff_we) pulses++;
      tick();
    end
    chk("mid_no_pulse", 32'(pulses), 32'd0);

    burst(12'd2, 12, 2, 2, 0);
    chk("post_rst_we_n", 32'(we_n), 32'd2);
    chk("post_rst_done_at", 32'(done_at), 32'd14);
    chk("post_rst_err_n", 32'(err_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
